// File: rtl/cdb_pkg.sv
// Shared types and sizing for the CDB result queues.
package cdb_pkg;

  localparam int PRF_SIZE    = 64;
  localparam int ROB_SIZE    = 16;
  localparam int PRF_IDX_W   = $clog2(PRF_SIZE);
  // Extra MSB carries the thread id.
  localparam int ROB_IDX_W   = $clog2(ROB_SIZE) + 1;
  localparam int CDB_Q_DEPTH = 4;

  typedef struct packed {
    logic [63:0]          result;
    logic [PRF_IDX_W-1:0] dest;
    logic [ROB_IDX_W-1:0] rob;
    logic                 br_taken;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_result_queue_if.sv
// FU-side, flush and CDB-side signals of one result queue.
interface cdb_result_queue_if;
  import cdb_pkg::*;

  logic                 fu_result_valid;
  logic [63:0]          fu_result_in;
  logic [PRF_IDX_W-1:0] fu_dest_reg_idx;
  logic [ROB_IDX_W-1:0] fu_rob_idx;
  logic                 fu_branch_taken;
  logic                 squash_valid;
  logic                 squash_thread;
  logic                 send_in_success;
  logic                 fu_stall;
  logic                 cdb_result_ready;
  logic [63:0]          cdb_result_out;
  logic [PRF_IDX_W-1:0] cdb_dest_reg_idx;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic                 cdb_branch_taken;

  // The queue itself.
  modport slave (
    input  fu_result_valid, fu_result_in, fu_dest_reg_idx, fu_rob_idx, fu_branch_taken,
    input  squash_valid, squash_thread, send_in_success,
    output fu_stall, cdb_result_ready, cdb_result_out, cdb_dest_reg_idx, cdb_rob_idx,
    output cdb_branch_taken
  );

  // The FU / arbiter environment around the queue.
  modport master (
    output fu_result_valid, fu_result_in, fu_dest_reg_idx, fu_rob_idx, fu_branch_taken,
    output squash_valid, squash_thread, send_in_success,
    input  fu_stall, cdb_result_ready, cdb_result_out, cdb_dest_reg_idx, cdb_rob_idx,
    input  cdb_branch_taken
  );

endinterface

// File: rtl/cdb_result_queue.sv
// Per-FU completion queue: buffers finished results until the CDB arbiter
// accepts them, back-pressures the FU when full and drops squashed entries.
module cdb_result_queue
  import cdb_pkg::*;
#(
  parameter int DEPTH = CDB_Q_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  cdb_result_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic     valid;
    cdb_pkt_t pkt;
  } entry_t;

  entry_t           q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic     full;
  logic     head_live;
  logic     push;
  logic     pop;
  logic     drop;
  logic     advance;
  logic     push_squashed;
  logic [PTR_W:0] count_next;
  cdb_pkt_t in_pkt;

  assign full = (count == (PTR_W+1)'(DEPTH));

  // Queue control: push/pop/drop decisions from registered state and inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    in_pkt        = '{result: bus.fu_result_in, dest: bus.fu_dest_reg_idx,
                      rob: bus.fu_rob_idx, br_taken: bus.fu_branch_taken};
    head_live     = (count != '0) && q[head].valid;
    push_squashed = bus.squash_valid && (bus.fu_rob_idx[ROB_IDX_W-1] == bus.squash_thread);
    // Stall comes from the registered count only, so a pop never frees a slot for the same cycle.
    push          = bus.fu_result_valid && !full && !push_squashed;
    pop           = bus.send_in_success && head_live;
    // A squashed head is retired silently, one per cycle.
    drop          = (count != '0) && !q[head].valid;
    advance       = pop || drop;
    count_next    = count + (PTR_W+1)'(push) - (PTR_W+1)'(advance);
  end

  // Storage and pointers; squash invalidation precedes the push into the free tail slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: the entry array is small, so the whole array is reset rather than only the valid bits; a larger RAM would reset valid bits only.
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so the later tail write overrides a squash clear on the same slot deterministically.
      if (bus.squash_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q[i].pkt.rob[ROB_IDX_W-1] == bus.squash_thread) q[i].valid <= 1'b0;
        end
      end
      if (push) begin
        q[tail] <= '{valid: 1'b1, pkt: in_pkt};
        tail    <= tail + PTR_W'(1);
      end
      // A pop of a head being squashed in the same cycle still advances: the CDB already broadcast it.
      if (advance) head <= head + PTR_W'(1);
      count <= count_next;
    end
  end

  assign bus.fu_stall         = full;
  assign bus.cdb_result_ready = head_live;
  assign bus.cdb_result_out   = head_live ? q[head].pkt.result   : '0;
  assign bus.cdb_dest_reg_idx = head_live ? q[head].pkt.dest     : '0;
  assign bus.cdb_rob_idx      = head_live ? q[head].pkt.rob      : '0;
  assign bus.cdb_branch_taken = head_live ? q[head].pkt.br_taken : 1'b0;

endmodule
